sr_cmd_arbiter: RTL and testbench
=================================

# sr_cmd_arbiter

Round-robin command arbiter and sequencer for a bank of `ffsr` SR flip-flops. Up to NREQ requesters issue set/clear commands against individual flags; the block serialises them, drives exactly one S or R pulse per command into the flip-flop bank, and reads back Q to confirm the write. It guarantees by construction that the bank never sees S=1 and R=1 together, and that it never sees more than one active S/R line at a time.

## Interface
- NREQ, default 4: number of requesters (2..8).
- NFLAG, default 8: number of flip-flops in the bank (2..64).
- IDXW, default $clog2(NFLAG): width of each flag index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester command request, level.
- op  in  NREQ  per-requester operation: 1 = set, 0 = clear.
- idx  in  NREQ*IDXW  per-requester target flag; requester i uses bits [i*IDXW +: IDXW].
- gnt  out  NREQ  one-hot grant pulse, 1 cycle.
- s_out  out  NFLAG  S lines to the flip-flop bank, registered.
- r_out  out  NFLAG  R lines to the flip-flop bank, registered.
- q_in  in  NFLAG  Q feedback from the flip-flop bank.
- done  out  1  1-cycle pulse when a command completes its readback check.
- err  out  1  sticky error flag.
- busy  out  1  high when the FSM is not in IDLE.

## Operation
- Reset (rst=0, asynchronous): state=IDLE, ptr=0, gnt=0, s_out=0, r_out=0, done=0, err=0, busy=0. All of these apply immediately, including mid-command. If reset lands mid-command, that command is lost and receives no done pulse.
- FSM has three states: IDLE, ISSUE, CHECK.
- **IDLE**
  - If any req bit is high, select the first requester at or after ptr, searching upward with wrap.
  - Latch that requester's op and idx, then go to ISSUE.
  - If no req bit is high, stay in IDLE.
- **ISSUE** (lasts 1 cycle)
  - gnt[sel]=1.
  - If op=1: s_out[idx]=1. If op=0: r_out[idx]=1. All other S/R bits are 0.
  - ptr ← (sel+1) mod NREQ.
  - If idx ≥ NFLAG: no S/R bit is driven, err ← 1, and the next state is IDLE (CHECK is skipped, no done pulse).
  - Otherwise the next state is CHECK.
- **CHECK** (lasts 1 cycle)
  - s_out=0, r_out=0.
  - Compare q_in[idx] against op. On mismatch, err ← 1.
  - done=1 regardless of the comparison result. Next state is IDLE.
- Invariants checked every cycle:
  - (s_out & r_out) == 0.
  - popcount(s_out | r_out) ≤ 1.
  - popcount(gnt) ≤ 1.
- Requester contract:
  - Hold req, op and idx stable until gnt is seen.
  - Dropping req before gnt withdraws the request with no effect.
  - A request held after gnt is treated as a new command.
- Commands that do not change the flag (set of an already-set flag, clear of a clear flag) are still issued and checked normally.
- Conflicting commands to the same flag (one set, one clear) execute in round-robin order. The flag's final value is the op of the later grant.
- err stays set until the next reset.

## Timing
- Edge k samples req with state=IDLE.
- After edge k: state=ISSUE; gnt, s_out and r_out are valid for one cycle.
- Edge k+1: the flip-flop bank captures S/R. After it, state=CHECK.
- Edge k+2: q_in is compared. After it, done=1 for one cycle and state=IDLE.
- Latency from req to done is 3 edges. Peak throughput is one command per 3 cycles.
- busy=1 during ISSUE and CHECK.
- The next arbitration happens at the edge after CHECK. A req that stays continuously high is granted again at the earliest on cycle k+3.
- q_in is assumed to be settled one cycle after the S/R pulse, i.e. the bank has single-cycle update latency.

## Test plan
- **Reset:** hold rst=0 with random req. Require gnt, s_out, r_out, done, err and busy all 0. Release rst at 14 ns; require the first grant to go to the lowest active requester.
- **Single set then clear:** req0 with op=1, idx=3. Require gnt[0] and s_out=8'h08 for exactly 1 cycle, then done with q_in[3]=1 and err=0. Then op=0 with the same idx: require r_out=8'h08 and q_in[3]=0.
- **Round-robin:** req=4'b1111 held continuously. Require grants in order 0,1,2,3,0 at 3-cycle spacing, and never two gnt bits high together.
- **Conflict:** req1 sets flag 5 and req2 clears flag 5 simultaneously. Require the set pulse then the clear pulse, the final q_in[5]=0, and s_out & r_out == 0 on every cycle.
- **Readback fault:** force q_in[2]=0 during a set of flag 2. Require done=1, err=1, and err still 1 after further good commands.
- **Reset mid-command:** drop rst during ISSUE. Require s_out, r_out and gnt to be 0 with no clock edge, no done pulse, and ptr=0 after release.

Source files
------------

// File: rtl/sr_cmd_arbiter_if.sv
// Bundle between the command arbiter and its surroundings: requester side,
// flip-flop bank side, status, and FSM/pointer debug visibility.
interface sr_cmd_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int NFLAG = 8,
   parameter int IDXW  = $clog2(NFLAG)
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Handshake: a requester raises req[i] with op/idx[i] stable and holds them
   // until it sees the 1-cycle gnt[i]; dropping req[i] before gnt withdraws the
   // request, keeping it high after gnt issues a fresh command.
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      op;
   logic [NREQ*IDXW-1:0] idx;
   logic [NREQ-1:0]      gnt;

   logic [NFLAG-1:0]     s_out;
   logic [NFLAG-1:0]     r_out;
   logic [NFLAG-1:0]     q_in;

   logic                 done;
   logic                 err;
   logic                 busy;

   logic [1:0]           state;
   logic [PW-1:0]        ptr;

   modport slave (
      input  req, op, idx, q_in,
      output gnt, s_out, r_out, done, err, busy, state, ptr
   );

   modport master (
      output req, op, idx, q_in,
      input  gnt, s_out, r_out, done, err, busy, state, ptr
   );
endinterface

// File: rtl/sr_cmd_arbiter.sv
// Round-robin set/clear command sequencer for an SR flip-flop bank: one S or R
// pulse per command, followed by a readback of Q that feeds a sticky error.
module sr_cmd_arbiter #(
   parameter int NREQ  = 4,
   parameter int NFLAG = 8,
   parameter int IDXW  = $clog2(NFLAG)
) (
   input  logic             clk,
   input  logic             rst,
   sr_cmd_arbiter_if.slave  bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             op_q, op_d;
   logic             bad_q, bad_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NFLAG-1:0] s_q, s_d;
   logic [NFLAG-1:0] r_q, r_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             found;
   logic [PW-1:0]    sel;
   logic             sel_op;
   logic [IDXW-1:0]  sel_idx;
   logic             sel_in_range;
   logic             q_bit;

   function automatic logic [NFLAG-1:0] decode(input logic [IDXW-1:0] i);
      logic [NFLAG-1:0] v;
      v = '0;
      for (int n = 0; n < NFLAG; n++) begin
         if (int'(i) == n) v[n] = 1'b1;
      end
      return v;
   endfunction

   // First active requester at or after ptr, searching upward with wrap.
   always_comb begin
      int c;
      c     = 0;
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < NREQ; k++) begin
         c = int'(ptr_q) + k;
         if (c >= NREQ) c = c - NREQ;
         if (!found && bus.req[c]) begin
            found = 1'b1;
            sel   = PW'(c);
         end
      end
   end

   always_comb begin
      sel_op       = bus.op[sel];
      sel_idx      = bus.idx[int'(sel)*IDXW +: IDXW];
      sel_in_range = (int'(sel_idx) < NFLAG);
      q_bit        = |(bus.q_in & decode(idx_q));
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      op_d    = op_q;
      bad_d   = bad_q;
      gnt_d   = '0;
      s_d     = '0;
      r_d     = '0;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = ISSUE;
               op_d    = sel_op;
               idx_d   = sel_idx;
               bad_d   = !sel_in_range;
               gnt_d   = NREQ'(1) << sel;
               // Exactly one S or R line; out-of-range targets drive nothing.
               if (sel_in_range) begin
                  if (sel_op) s_d = decode(sel_idx);
                  else        r_d = decode(sel_idx);
               end
               ptr_d = (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
            end
         end
         ISSUE: begin
            if (bad_q) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            done_d  = 1'b1;
            if (q_bit != op_q) err_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         op_q    <= 1'b0;
         bad_q   <= 1'b0;
         gnt_q   <= '0;
         s_q     <= '0;
         r_q     <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         bad_q   <= bad_d;
         gnt_q   <= gnt_d;
         s_q     <= s_d;
         r_q     <= r_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.s_out = s_q;
   assign bus.r_out = r_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;
   assign bus.busy  = (state_q != IDLE);
   assign bus.state = state_q;
   assign bus.ptr   = ptr_q;

   a_no_set_and_reset: assert property (@(posedge clk) disable iff (!rst)
      (s_q & r_q) == '0);
   a_one_sr_line: assert property (@(posedge clk) disable iff (!rst)
      $onehot0(s_q | r_q));
   a_one_grant: assert property (@(posedge clk) disable iff (!rst)
      $onehot0(gnt_q));
   a_pulse_with_grant: assert property (@(posedge clk) disable iff (!rst)
      ((s_q | r_q) != '0) |-> (gnt_q != '0));
endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Directed and randomized checks of sr_cmd_arbiter against a transaction-level
// model of round-robin order, flag values and the sticky error.
module tb_sr_cmd_arbiter;
   localparam int NREQ  = 4;
   localparam int NFLAG = 8;
   localparam int IDXW  = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sr_cmd_arbiter_if #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) bus ();

   sr_cmd_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // SR flip-flop bank with single-cycle update; fault_mask forces Q bits low.
   logic [NFLAG-1:0] q_bank     = '0;
   logic [NFLAG-1:0] fault_mask = '0;
   always @(posedge clk) q_bank <= (q_bank | bus.s_out) & ~bus.r_out;
   assign bus.q_in = q_bank & ~fault_mask;

   int               n_checks = 0;
   int               n_errors = 0;
   int               m_ptr    = 0;
   logic             m_err    = 1'b0;
   logic [NFLAG-1:0] m_flag   = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         chk("inv_s_and_r", 64'(bus.s_out & bus.r_out), 64'(0));
         chk("inv_one_sr", 64'($countones(bus.s_out | bus.r_out) <= 1), 64'(1));
         chk("inv_one_gnt", 64'($countones(bus.gnt) <= 1), 64'(1));
      end
   end

   // One full command: grant after one edge, pulse, check cycle, done pulse.
   task automatic expect_cmd(input string tag, input bit drop);
      int               w;
      int               waits;
      int               ix;
      logic             o;
      logic [NFLAG-1:0] one;
      w = rr_pick(bus.req, m_ptr);
      if (w < 0) begin
         $display("FAIL %s no active requester in stimulus", tag);
         $fatal(1);
      end
      o     = bus.op[w];
      ix    = int'(bus.idx[w*IDXW +: IDXW]);
      one   = NFLAG'(1) << ix;
      waits = 0;
      do begin
         @(posedge clk); #1;
         waits++;
      end while (bus.gnt == '0 && waits < 6);
      chk({tag, "_latency"}, 64'(waits), 64'(1));
      chk({tag, "_gnt"}, 64'(bus.gnt), 64'(NREQ'(1) << w));
      chk({tag, "_s_pulse"}, 64'(bus.s_out), o ? 64'(one) : 64'(0));
      chk({tag, "_r_pulse"}, 64'(bus.r_out), o ? 64'(0) : 64'(one));
      chk({tag, "_busy_issue"}, 64'(bus.busy), 64'(1));
      chk({tag, "_done_issue"}, 64'(bus.done), 64'(0));
      m_ptr = (w + 1) % NREQ;
      if (drop) bus.req[w] = 1'b0;
      @(posedge clk); #1;
      m_flag[ix] = o;
      chk({tag, "_s_idle"}, 64'(bus.s_out), 64'(0));
      chk({tag, "_r_idle"}, 64'(bus.r_out), 64'(0));
      chk({tag, "_gnt_clr"}, 64'(bus.gnt), 64'(0));
      chk({tag, "_busy_check"}, 64'(bus.busy), 64'(1));
      chk({tag, "_done_check"}, 64'(bus.done), 64'(0));
      @(posedge clk); #1;
      if ((m_flag[ix] & ~fault_mask[ix]) != o) m_err = 1'b1;
      chk({tag, "_done"}, 64'(bus.done), 64'(1));
      chk({tag, "_busy_done"}, 64'(bus.busy), 64'(0));
      chk({tag, "_err"}, 64'(bus.err), 64'(m_err));
      chk({tag, "_q"}, 64'(bus.q_in), 64'(m_flag & ~fault_mask));
   endtask

   task automatic set_req(input int i, input logic o, input int ix);
      bus.op[i]              = o;
      bus.idx[i*IDXW +: IDXW] = IDXW'(ix);
      bus.req[i]             = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset with random requests pending.
      bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      bus.op  = NREQ'($urandom);
      bus.idx = (NREQ*IDXW)'($urandom);
      #8;
      chk("rst_gnt", 64'(bus.gnt), 64'(0));
      chk("rst_s", 64'(bus.s_out), 64'(0));
      chk("rst_r", 64'(bus.r_out), 64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));
      chk("rst_err", 64'(bus.err), 64'(0));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      #6 rst = 1'b1;
      expect_cmd("rst_first", 1'b1);
      bus.req = '0;

      // Single set then clear of flag 3 by requester 0.
      set_req(0, 1'b1, 3);
      expect_cmd("set3", 1'b1);
      chk("set3_q3", 64'(bus.q_in[3]), 64'(1));
      set_req(0, 1'b0, 3);
      expect_cmd("clr3", 1'b1);
      chk("clr3_q3", 64'(bus.q_in[3]), 64'(0));

      // Move the pointer back to 0, then all four requesters held.
      set_req(3, 1'($urandom_range(0, 1)), $urandom_range(0, NFLAG - 1));
      expect_cmd("rr_prep", 1'b1);
      bus.req = '0;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, NFLAG - 1));
      for (int n = 0; n < 5; n++) expect_cmd("rr", 1'b0);
      bus.req = '0;

      // Conflicting set and clear of flag 5.
      set_req(1, 1'b1, 5);
      set_req(2, 1'b0, 5);
      expect_cmd("conf_set", 1'b1);
      expect_cmd("conf_clr", 1'b1);
      chk("conf_q5", 64'(bus.q_in[5]), 64'(0));
      bus.req = '0;

      // Readback fault on flag 2, then good commands keep err sticky.
      fault_mask[2] = 1'b1;
      set_req(0, 1'b1, 2);
      expect_cmd("fault", 1'b1);
      fault_mask[2] = 1'b0;
      set_req(1, 1'b1, 6);
      expect_cmd("after_fault_a", 1'b1);
      set_req(2, 1'b0, 6);
      expect_cmd("after_fault_b", 1'b1);
      chk("err_sticky", 64'(bus.err), 64'(1));

      // Random traffic.
      for (int n = 0; n < 20; n++) begin
         bus.op  = NREQ'($urandom);
         bus.idx = (NREQ*IDXW)'($urandom);
         bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         expect_cmd("rand", 1'b1);
         bus.req = '0;
      end

      // Reset while the ISSUE pulse is on the bank.
      set_req(0, 1'b1, 7);
      @(posedge clk); #1;
      chk("mid_gnt", 64'(bus.gnt), 64'(1));
      bus.req = '0;
      #2 rst = 1'b0;
      #1;
      m_err = 1'b0;
      m_ptr = 0;
      chk("mid_gnt_clr", 64'(bus.gnt), 64'(0));
      chk("mid_s_clr", 64'(bus.s_out), 64'(0));
      chk("mid_r_clr", 64'(bus.r_out), 64'(0));
      chk("mid_busy", 64'(bus.busy), 64'(0));
      chk("mid_err", 64'(bus.err), 64'(0));
      chk("mid_ptr", 64'(bus.ptr), 64'(0));
      chk("mid_state", 64'(bus.state), 64'(0));
      for (int n = 0; n < 2; n++) begin
         @(posedge clk); #1;
         chk("mid_no_done", 64'(bus.done), 64'(0));
      end
      chk("mid_q_unchanged", 64'(bus.q_in), 64'(m_flag));
      #2 rst = 1'b1;
      @(negedge clk);
      set_req(0, 1'($urandom_range(0, 1)), $urandom_range(0, NFLAG - 1));
      set_req(3, 1'($urandom_range(0, 1)), $urandom_range(0, NFLAG - 1));
      expect_cmd("post_rst", 1'b1);
      bus.req = '0;
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
